// File: rtl/game_step_scheduler.sv
// Frame scheduler for the Pong datapath: counts millisecond ticks into frames and
// runs the paddle, ball, collide and score units in order through a start/done handshake.
module game_step_scheduler #(
  parameter int unsigned FRAME_MS    = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1ms,
  input  logic       enable,
  input  logic [3:0] step_done,
  input  logic       clr_err,
  output logic [3:0] step_start,
  output logic [1:0] phase,
  output logic       busy,
  output logic       frame_tick,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_MS - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYC - 1);

  state_t     state_q, state_d;
  logic       clk_1ms_q;
  logic [7:0] ms_cnt_q, ms_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] step_start_q, step_start_d;
  logic       busy_q, busy_d;
  logic       frame_tick_q, frame_tick_d;
  logic       overrun_q, overrun_d;
  logic       timeout_err_q, timeout_err_d;

  logic ms_tick, frame_req, done_sel, ovr_evt, to_evt;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    ms_tick   = clk_1ms & ~clk_1ms_q;
    ms_cnt_d  = ms_cnt_q;
    frame_req = 1'b0;
    if (ms_tick && enable) begin
      if (ms_cnt_q == FRAME_LAST) begin
        ms_cnt_d  = 8'd0;
        frame_req = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    to_evt     = 1'b0;
    done_sel   = step_done[phase_q];
    unique case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          state_d = S_START;
          phase_d = 2'd0;
        end
      end
      S_START: begin
        state_d    = S_WAIT;
        wait_cnt_d = 8'd0;
      end
      S_WAIT: begin
        // A done that lands on the deadline cycle counts as an answer, not a timeout.
        if (done_sel || wait_cnt_q == WAIT_LAST) begin
          to_evt = ~done_sel;
          if (phase_q == 2'd3) begin
            state_d = S_IDLE;
            phase_d = 2'd0;
          end else begin
            state_d = S_START;
            phase_d = phase_q + 2'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
      end
    endcase

    ovr_evt       = frame_req && (state_q != S_IDLE);
    busy_d        = (state_d != S_IDLE);
    frame_tick_d  = frame_req && (state_q == S_IDLE);
    step_start_d  = (state_d == S_START) ? (4'b0001 << phase_d) : 4'b0000;
    overrun_d     = ovr_evt | (overrun_q & ~clr_err);
    timeout_err_d = to_evt | (timeout_err_q & ~clr_err);
  end

  // NOTE: non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clk_1ms_q     <= 1'b0;
      ms_cnt_q      <= 8'd0;
      wait_cnt_q    <= 8'd0;
      phase_q       <= 2'd0;
      step_start_q  <= 4'b0000;
      busy_q        <= 1'b0;
      frame_tick_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_1ms_q     <= clk_1ms;
      ms_cnt_q      <= ms_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      phase_q       <= phase_d;
      step_start_q  <= step_start_d;
      busy_q        <= busy_d;
      frame_tick_q  <= frame_tick_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign step_start  = step_start_q;
  assign phase       = phase_q;
  assign busy        = busy_q;
  assign frame_tick  = frame_tick_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
// Scoreboard bench for game_step_scheduler: a frame-timeline model predicts start pulses
// and flags from the ms wave, enable, clr_err and the unit latencies the bench picks.
module tb_game_step_scheduler;

  localparam int FRAME_MS    = 4;
  localparam int TIMEOUT_CYC = 10;
  localparam int NEVER       = 255;

  logic       clk = 1'b0;
  logic       rst_n, clk_1ms, enable, clr_err;
  logic [3:0] step_done;
  logic [3:0] step_start;
  logic [1:0] phase;
  logic       busy, frame_tick, overrun, timeout_err;

  game_step_scheduler #(.FRAME_MS(FRAME_MS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms), .enable(enable),
    .step_done(step_done), .clr_err(clr_err), .step_start(step_start),
    .phase(phase), .busy(busy), .frame_tick(frame_tick),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       tick;
    logic [3:0] start;
  } ev_t;

  ev_t exp_q[$];
  int  lat_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
    end
  endtask

  // Reference model: one frame timeline at a time (start cycle and WAIT length per unit).
  int   ms_cnt_m;
  logic prev_lvl;
  logic exp_busy, exp_ovr, exp_to;
  logic [1:0] exp_phase;
  bit   fr_active;
  int   fs[4], fw[4], fend;
  bit   fto[4];
  bit   accepted;

  // Stimulus and unit-responder state.
  int per = 20, ph = 0, clr_pct = 0;
  bit en_drv = 1'b0, clr_always = 1'b0, force_lat = 1'b0;
  int forced[4];
  int r_unit = -1, r_w = 0, r_lat = 0;

  function automatic int gen_lat(input int k);
    int r;
    if (force_lat) return forced[k];
    r = int'($urandom_range(0, 9));
    if (r < 2) return NEVER;
    return int'($urandom_range(0, TIMEOUT_CYC - 2));
  endfunction

  function automatic bit in_frame(input int n);
    return fr_active && n >= fs[0] && n <= fend;
  endfunction

  function automatic logic [1:0] phase_at(input int n);
    if (!fr_active) return 2'd0;
    for (int k = 0; k < 4; k++)
      if (n >= fs[k] && n <= fs[k] + fw[k]) return 2'(k);
    return 2'd0;
  endfunction

  function automatic bit to_at(input int n);
    if (!fr_active) return 1'b0;
    for (int k = 0; k < 4; k++)
      if (fto[k] && n == fs[k] + fw[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic accept(input int c);
    int s, lat;
    s = c + 1;
    for (int k = 0; k < 4; k++) begin
      lat = gen_lat(k);
      lat_q.push_back(lat);
      fs[k]  = s;
      fto[k] = (lat >= TIMEOUT_CYC);
      fw[k]  = fto[k] ? TIMEOUT_CYC : lat + 1;
      exp_q.push_back('{cyc: s, tick: (k == 0), start: 4'(1 << k)});
      s = s + fw[k] + 1;
    end
    fend      = fs[3] + fw[3];
    fr_active = 1'b1;
    accepted  = 1'b1;
  endtask

  task automatic model_reset();
    ms_cnt_m  = 0;
    prev_lvl  = 1'b0;
    exp_busy  = 1'b0;
    exp_ovr   = 1'b0;
    exp_to    = 1'b0;
    exp_phase = 2'd0;
    fr_active = 1'b0;
    r_unit    = -1;
    exp_q.delete();
    lat_q.delete();
  endtask

  // One clock cycle, entered at the falling edge: check state, answer as the units, drive inputs, advance the model.
  task automatic cycle_body();
    int n;
    logic [3:0] d;
    logic lvl, clr, req, busy_n, ovr_set, to_set;
    n = cyc;
    check("busy", 32'(busy), 32'(exp_busy));
    check("phase", 32'(phase), 32'(exp_phase));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("timeout_err", 32'(timeout_err), 32'(exp_to));

    d = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    if (step_start != 4'b0000) begin
      for (int k = 0; k < 4; k++) if (step_start[k]) r_unit = k;
      r_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      r_w   = -1;
      d[r_unit] = 1'($urandom_range(0, 1));
    end else if (r_unit >= 0) begin
      r_w++;
      d[r_unit] = (r_w == r_lat);
      if (r_w == r_lat || r_w >= TIMEOUT_CYC - 1) r_unit = -1;
    end
    step_done = d;

    lvl = (ph < (per + 1) / 2);
    ph  = (ph + 1 >= per) ? 0 : ph + 1;
    clr = clr_always || (int'($urandom_range(0, 99)) < clr_pct);
    clk_1ms = lvl;
    enable  = en_drv;
    clr_err = clr;

    req = 1'b0;
    if (lvl && !prev_lvl && en_drv) begin
      if (ms_cnt_m == FRAME_MS - 1) begin
        ms_cnt_m = 0;
        req      = 1'b1;
      end else begin
        ms_cnt_m++;
      end
    end
    prev_lvl = lvl;
    busy_n   = in_frame(n);
    ovr_set  = req && busy_n;
    if (req && !busy_n) accept(n);
    to_set    = to_at(n);
    exp_ovr   = ovr_set || (exp_ovr && !clr);
    exp_to    = to_set || (exp_to && !clr);
    exp_busy  = in_frame(n + 1);
    exp_phase = phase_at(n + 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cycle_body();
    end
  endtask

  task automatic wait_accept();
    int i = 0;
    accepted = 1'b0;
    while (!accepted && i < 400) begin
      @(negedge clk);
      cycle_body();
      i++;
    end
    if (!accepted) check("frame_accept_bound", 32'(0), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step_start"}, 32'(step_start), 32'(0));
    check({tag, "_phase"}, 32'(phase), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'(0));
    check({tag, "_overrun"}, 32'(overrun), 32'(0));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
  endtask

  // Scoreboard monitor: every start pulse / frame tick must match the next expected event.
  ev_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        check("event_missing", 32'(cyc), 32'(mon_e.cyc));
      end
      if (frame_tick || step_start != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("event_unexpected", {27'd0, frame_tick, step_start}, 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("event_frame_tick", 32'(frame_tick), 32'(mon_e.tick));
          check("event_step_start", 32'(step_start), 32'(mon_e.start));
        end
      end
    end
  end

  initial begin
    int i;
    rst_n     = 1'b0;
    clk_1ms   = 1'b0;
    enable    = 1'b0;
    clr_err   = 1'b0;
    step_done = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle_body();

    // Nominal frames: 80-clk frame period, starts 5 clk apart, busy 20 clk.
    per = 20; en_drv = 1'b1; force_lat = 1'b1; forced = '{3, 3, 3, 3};
    run(400);

    // Ball unit never answers: forced advance after the timeout, frame still completes.
    forced = '{3, NEVER, 3, 3};
    run(170);

    // Pause 2 ms into a frame period for 10 ms, then resume.
    forced = '{3, 3, 3, 3};
    wait_accept();
    run(2 * per + 3);
    en_drv = 1'b0;
    run(10 * per);
    en_drv = 1'b1;
    run(200);

    // Pause with a sequence in flight: it must still finish.
    wait_accept();
    run(3);
    en_drv = 1'b0;
    run(100);
    en_drv = 1'b1;

    // Overrun: short frames, slow units, clr_err held so the set/clear collision is exercised.
    per = 3; forced = '{8, 8, 8, 8}; clr_always = 1'b1;
    run(150);
    clr_always = 1'b0;
    run(100);
    en_drv = 1'b0;
    run(60);
    clr_always = 1'b1;
    run(2);
    clr_always = 1'b0;

    // Reset in the middle of the collide unit's WAIT.
    per = 20; en_drv = 1'b1; forced = '{1, 1, NEVER, 1};
    i = 0;
    while (!(r_unit == 2 && r_w >= 2) && i < 500) begin
      @(negedge clk);
      cycle_body();
      i++;
    end
    if (i >= 500) check("reach_collide_wait_bound", 32'(0), 32'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    step_done = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle_body();
    forced = '{3, 3, 3, 3};
    run(300);

    // Randomized traffic.
    force_lat = 1'b0;
    for (int b = 0; b < 30; b++) begin
      per     = int'($urandom_range(2, 25));
      en_drv  = ($urandom_range(0, 3) != 0);
      clr_pct = int'($urandom_range(0, 10));
      run(int'($urandom_range(50, 200)));
    end

    en_drv = 1'b0; clr_pct = 0;
    run(120);
    check("pending_events", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_step_scheduler.md
Name: game_step_scheduler

Overview:
- Frame-level scheduler for the Pong game logic.
- Consumes the 1 kHz square wave from the millisecond timer and counts FRAME_MS milliseconds per game frame.
- At each frame boundary, runs four game datapath units in fixed order with a start/done handshake: paddle update, ball move, collision check, score update.
- Flags frame overruns and unit timeouts so the top level can show them on LEDs.

Parameters:
- FRAME_MS, 16: milliseconds per game frame; legal range 1..255.
- TIMEOUT_CYC, 255: maximum clk cycles to wait for a unit's done before forcing advance; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clk_1ms  in  1  1 kHz square wave from the ms timer; generated in the clk domain, so no synchroniser.
- enable  in  1  1 = run, 0 = pause.
- step_done  in  4  per-unit done pulses; bit0 paddle, bit1 ball, bit2 collide, bit3 score.
- clr_err  in  1  clears the sticky error flags.
- step_start  out  4  one-hot, one-cycle start pulse to the selected unit.
- phase  out  2  index of the active unit.
- busy  out  1  high while a frame sequence is in progress.
- frame_tick  out  1  one-cycle pulse at each accepted frame start.
- overrun  out  1  sticky flag: a frame boundary arrived while busy.
- timeout_err  out  1  sticky flag: a unit missed its done deadline.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs are 0. State=IDLE, ms_cnt=0, wait_cnt=0, edge-detect register=0.
- Millisecond tick:
  - ms_tick = clk_1ms & ~clk_1ms_q, where clk_1ms_q is clk_1ms registered on clk.
  - One ms_tick per rising edge of clk_1ms.
- Millisecond counter (ms_cnt, 8 bit):
  - Increments on ms_tick only while enable=1; holds while enable=0.
  - On ms_tick with ms_cnt==FRAME_MS-1: ms_cnt wraps to 0 and frame_req=1 for that cycle.
- State machine: IDLE, START, WAIT.
  - IDLE, frame_req=1: next cycle state=START, phase=0, busy=1. frame_tick pulses on the same edge (registered, 1 cycle after frame_req).
  - START: step_start[phase]=1 for exactly this cycle. wait_cnt=0. Go to WAIT.
  - WAIT: wait_cnt increments each cycle. The block samples step_done[phase] only in this state; other done bits and done pulses seen in START are ignored.
  - WAIT advance condition: step_done[phase]=1, or wait_cnt==TIMEOUT_CYC-1. A timeout also sets timeout_err.
  - WAIT, on advance with phase<3: phase+1, go to START.
  - WAIT, on advance with phase==3: go to IDLE, busy=0, phase=0.
- Minimum frame length: 4 START cycles + 4 WAIT cycles = 8 clk with immediate done.
- frame_req while busy: the request is dropped (never queued) and overrun is set.
- enable=0 mid-frame: the current sequence completes normally; no new frame_req is produced.
- Sticky flags: clr_err=1 clears overrun and timeout_err. If a set event and clr_err occur in the same cycle, the set wins.
- rst_n asserted mid-sequence: immediate return to IDLE. Any start pulse in flight is cut; no completion is emitted.
- Outputs are registered. There are no combinational paths from step_done to step_start.

Test Plan:
- Reset then run, FRAME_MS=4, clk_1ms period 20 clk, units answer done 3 cycles after start:
  - frame_tick occurs once every 80 clk.
  - step_start sequence is 0001, 0010, 0100, 1000, spaced 5 clk apart.
  - busy is high for 20 clk.
- Timeout, TIMEOUT_CYC=10, ball unit never answers:
  - step_start[2] rises 11 clk after step_start[1].
  - timeout_err=1; the sequence still finishes at phase 3.
- Overrun, FRAME_MS=1, units take 30 clk:
  - the second boundary arrives while busy; overrun=1, with no extra frame_tick.
  - clr_err with no new event -> overrun returns to 0.
  - clr_err in the same cycle as a new overrun -> overrun stays 1.
- Pause: drop enable after 2 ms of a 4 ms frame, hold 10 ms, re-raise:
  - the next frame_tick occurs exactly 2 ms of ticks later.
  - an in-progress sequence completes during the pause.
- Spurious done:
  - step_done[3] and step_done[0] asserted while phase=1 -> ignored, state remains WAIT.
  - done pulse in the START cycle -> ignored.
- Reset mid-WAIT at phase 2: outputs 0 asynchronously; after release, the next frame begins at phase 0 after FRAME_MS ms.
